// File: rtl/decrementer_seq_pkg.sv
// Shared ALU definitions: default operand width and the decrementer state encodings.
// The incrementer and adder use the same default width.
package decrementer_seq_pkg;

  localparam int ALU_WIDTH = 3;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_RUN  = 2'd1,
    DEC_DONE = 2'd2
  } dec_state_t;

endpackage

// File: rtl/decrementer_seq_if.sv
// Request/status bundle for decrementer_seq; DECREMENTER_ABORT_EN adds the abort request.
// The master drives requests and the slave (the counter) returns registered status.
interface decrementer_seq_if
  import decrementer_seq_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             dec;
`ifdef DECREMENTER_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             done_o;
  logic             borrow_o;
  logic             zero_o;

`ifdef DECREMENTER_ABORT_EN
  modport master (output start, din, en, dec, abort,
                  input  count_o, busy_o, done_o, borrow_o, zero_o);
  modport slave  (input  start, din, en, dec, abort,
                  output count_o, busy_o, done_o, borrow_o, zero_o);
`else
  modport master (output start, din, en, dec,
                  input  count_o, busy_o, done_o, borrow_o, zero_o);
  modport slave  (input  start, din, en, dec,
                  output count_o, busy_o, done_o, borrow_o, zero_o);
`endif

endinterface

// File: rtl/decrementer_seq_dec_core.sv
// Combinational subtract-by-one built from a half-subtractor chain; zero latency.
// borrow is the borrow out of the top bit, so it is set only when value is zero.
module dec_core
  import decrementer_seq_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] bchain;

  always_comb begin
    bchain    = '0;
    diff      = '0;
    bchain[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]       = value[i] ^ bchain[i];
      bchain[i + 1] = ~value[i] & bchain[i];
    end
    borrow = bchain[WIDTH];
  end

endmodule

// File: rtl/decrementer_seq.sv
// Step/run down-counter; outputs registered one cycle after the request, zero_o decoded from count.
// No backpressure: requests outside IDLE are dropped. DECREMENTER_ABORT_EN adds a RUN abort.
module decrementer_seq
  import decrementer_seq_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  decrementer_seq_if.slave bus
);

  dec_state_t       state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt, count_m1;
  logic             busy, done, borrow;
  logic             borrow_nxt, step_borrow;

  dec_core #(.WIDTH(WIDTH)) u_core (
    .value  (count),
    .diff   (count_m1),
    .borrow (step_borrow)
  );

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    borrow_nxt = 1'b0;
    case (state)
      DEC_IDLE: begin
        // start has priority; a simultaneous dec is dropped
        if (bus.start) begin
          count_nxt = bus.din;
          if (bus.din == '0) state_nxt = DEC_DONE;
          else               state_nxt = DEC_RUN;
        end else if (bus.dec) begin
          count_nxt  = count_m1;
          borrow_nxt = step_borrow;
        end
      end
      DEC_RUN: begin
`ifdef DECREMENTER_ABORT_EN
        if (bus.abort) begin
          state_nxt = DEC_IDLE;
        end else
`endif
        if (bus.en) begin
          count_nxt = count_m1;
          if (count == WIDTH'(1)) state_nxt = DEC_DONE;
        end
      end
      DEC_DONE: state_nxt = DEC_IDLE;
      default:  state_nxt = DEC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DEC_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      borrow <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      busy   <= (state_nxt == DEC_RUN);
      done   <= (state_nxt == DEC_DONE);
      borrow <= borrow_nxt;
    end
  end

  assign bus.count_o  = count;
  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.borrow_o = borrow;
  assign bus.zero_o   = (count == '0);

endmodule

// File: doc/decrementer_seq.md
Name: decrementer_seq

Overview:
- Sequential N-bit down-counter; the decrementing counterpart to the team's incrementer.
- Two modes:
  - Step mode: single decrement per request, wraps with borrow.
  - Run mode: a loaded value counts down to zero, then `done` pulses.
- Sits in the ALU datapath beside the incrementer and adder; provides loop/timer counts and -1 operations.

Parameters:
- WIDTH, 3, counter width in bits (the bench uses 3 to mirror the incrementer's 3-bit operand).

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  run-mode request; samples din; honoured only in IDLE
- din  input  WIDTH  value loaded on an accepted start
- en  input  1  run-mode count enable; low holds the count in RUN
- dec  input  1  step-mode decrement request; honoured only in IDLE
- count_o  output  WIDTH  current counter register
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle pulse on entering DONE
- borrow_o  output  1  one-cycle pulse when a step wraps 0 -> 2^WIDTH-1
- zero_o  output  1  count_o == 0, decoded from the register

Behaviour:
- Reset (async assert, sync-released by the clock domain):
  - state = IDLE.
  - count_o = 0, busy_o = 0, done_o = 0, borrow_o = 0.
  - zero_o = 1.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1, din != 0: count <= din; next RUN. busy_o is high from the next cycle.
  - start=1, din == 0: count <= 0; next DONE. No RUN cycle.
  - start=0, dec=1: count <= count-1 mod 2^WIDTH.
  - Step from count == 0: count <= all-ones and borrow_o = 1 for exactly the next cycle.
  - start and dec both 1: start wins; dec is dropped and borrow_o stays 0.
- RUN:
  - en=1: count <= count-1.
  - count == 1 with en=1: count <= 0; next DONE.
  - en=0: count and state hold.
  - start and dec are ignored; din is not sampled.
  - RUN never wraps; borrow_o stays 0.
- DONE:
  - done_o = 1 for this single cycle; busy_o = 0; count_o = 0.
  - Next state is IDLE unconditionally.
  - start or dec in DONE is ignored; the requester retries in IDLE.
- Latency:
  - Loading N (N > 0) gives N RUN cycles with en held high.
  - done_o is asserted in cycle N+1 after the start edge.
- Output timing:
  - All outputs except zero_o are registered.
  - zero_o is a pure decode of the count register, so there is no input-to-output combinational path.
- Reset mid-operation: immediate return to reset values. No done_o is issued for the aborted run.
- Arithmetic:
  - Unsigned, WIDTH bits; subtraction is modulo 2^WIDTH.
  - borrow_o is the carry-out inverse of the step subtract.

Optional Feature:
- Macro: DECREMENTER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN: next IDLE; count holds its current value; no done_o.
  - abort has priority over en.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; RUN exits only via reaching zero or reset.

Decomposition:
- Shared include file alu_defs.vh holds:
  - State encodings DEC_IDLE=2'd0, DEC_RUN=2'd1, DEC_DONE=2'd2.
  - Default width constant ALU_WIDTH=3, also used by the incrementer and adder.
- One natural sub-module: dec_core.
  - Combinational WIDTH-bit subtract-by-one producing value-1 and borrow.
  - Built from per-bit half-subtractor logic, mirroring the incrementer's half-adder chain.
  - The FSM and registers stay in decrementer_seq.

Test Plan (WIDTH=3):
1. Reset: rst_n=0 mid-cycle -> count_o=0, zero_o=1, busy_o=0, done_o=0, borrow_o=0 immediately, without a clock edge.
2. Run: start=1, din=3, en=1 held -> count_o 3,2,1,0; busy_o high 3 cycles; done_o one pulse in cycle 4; then IDLE.
3. Zero load and start in RUN:
   - start=1, din=0 -> no busy_o; done_o pulse next cycle.
   - start=1, din=5 issued during RUN -> ignored; count continues unchanged.
4. Step wrap and priority:
   - IDLE count=0, dec=1 -> count_o=7, borrow_o one-cycle pulse.
   - dec again -> count_o=6, borrow_o=0.
   - start=1, dec=1 together with din=2 -> count_o=2, no borrow.
5. Hold: RUN from din=4, en low 2 cycles after first decrement -> count_o stays 3 for 2 cycles; done_o arrives 2 cycles later than case 2 timing.
6. Reset mid-run and abort:
   - rst_n low while count_o=2 -> IDLE, count 0, no done_o.
   - With DECREMENTER_ABORT_EN: abort at count 2 -> IDLE, count_o=2, no done_o.
